// File: rtl/foobar_logger_if.sv
// Event-capture and record-stream signals of the foobar logger.
// slave is the logger's view; master is the producer/consumer side.
interface foobar_logger_if;
    logic        en;
    logic        foo;
    logic        bar;
    logic [7:0]  count_foo;
    logic [7:0]  count_bar;
    logic        out_ready;
    logic        out_valid;
    logic [25:0] out_data;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;
    logic        overflow;

    modport slave (
        input  en, foo, bar, count_foo, count_bar, out_ready,
        output out_valid, out_data, level, drop_cnt, overflow
    );

    modport master (
        output en, foo, bar, count_foo, count_bar, out_ready,
        input  out_valid, out_data, level, drop_cnt, overflow
    );
endinterface

// File: rtl/foobar_logger.sv
// Captures foobar events into a first-word-fall-through record FIFO with overflow accounting.
// Define FOOBAR_LOGGER_STAMP_EN to build the 8-bit enable-cycle stamp counter; otherwise stamps are zero.
module foobar_logger #(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    foobar_logger_if.slave bus
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_LVL = 5'(DEPTH);

    logic [25:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level_q;
    logic [7:0]    drop_q;
    logic          ovf_q;
    logic [7:0]    stamp;

    logic       event_hit;
    logic       full;
    logic       pop;
    logic       push;
    logic [1:0] kind;

    always_comb begin
        event_hit = bus.en & (bus.foo | bus.bar);
        kind      = {bus.bar, bus.foo};
        full      = (level_q == FULL_LVL);
        pop       = (level_q != 5'd0) & bus.out_ready;
        // a full FIFO still accepts when its head leaves on the same edge
        push      = event_hit & (~full | pop);
    end

`ifdef FOOBAR_LOGGER_STAMP_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stamp <= 8'h00;
        else if (bus.en)
            stamp <= stamp + 8'h01;
    end
`else
    assign stamp = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wr_ptr] <= {kind, stamp, bus.count_foo, bus.count_bar};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= 5'd0;
            drop_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                level_q <= level_q + 5'd1;
            else if (pop && !push)
                level_q <= level_q - 5'd1;
            if (event_hit && full && !pop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'h01;
            end
        end
    end

    assign bus.out_valid = (level_q != 5'd0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 26'd0;
    assign bus.level     = level_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_foobar_logger.sv
// Randomized and directed scoreboard bench for foobar_logger against a queue-based reference model.
module tb_foobar_logger;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    foobar_logger_if bus ();

    foobar_logger #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [25:0] m_q[$];
    logic [25:0] sb_q[$];
    int          m_stamp = 0;
    int          m_drop  = 0;
    bit          m_ovf   = 1'b0;

    bit         p_rst = 1'b0, p_en = 1'b0, p_foo = 1'b0, p_bar = 1'b0, p_rdy = 1'b0;
    logic [7:0] p_cf = 8'h00, p_cb = 8'h00;

    int checks  = 0;
    int passes  = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: applies the inputs sampled at the edge just passed.
    task automatic model_update();
        bit          full, pop, ev;
        logic [1:0]  kind;
        logic [7:0]  st;
        logic [25:0] rec;
        if (!p_rst) begin
            m_q.delete();
            sb_q.delete();
            m_stamp = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && p_rdy;
            ev   = p_en && (p_foo || p_bar);
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (p_foo && p_bar) kind = 2'b11;
                else if (p_foo)     kind = 2'b01;
                else                kind = 2'b10;
`ifdef FOOBAR_LOGGER_STAMP_EN
                st = 8'(m_stamp);
`else
                st = 8'h00;
`endif
                rec = {kind, st, p_cf, p_cb};
                if (!full || pop) begin
                    m_q.push_back(rec);
                    sb_q.push_back(rec);
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            if (p_en) m_stamp = (m_stamp + 1) % 256;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit f, input bit b,
                        input logic [7:0] cf, input logic [7:0] cb, input bit rdy);
        @(posedge clk);
        #1;
        model_update();
        rst = r;  bus.en = e;  bus.foo = f;  bus.bar = b;
        bus.count_foo = cf;  bus.count_bar = cb;  bus.out_ready = rdy;
        p_rst = r;  p_en = e;  p_foo = f;  p_bar = b;
        p_cf = cf;  p_cb = cb;  p_rdy = rdy;
    endtask

    task automatic idle(input int n, input bit e, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 1'b0, 8'h00, 8'h00, rdy);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            check("level", 32'(bus.level), 32'(m_q.size()));
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL head: got %0h expected no record at %0t", bus.out_data, $time);
                end else begin
                    check("head", 32'(bus.out_data), 32'(sb_q[0]));
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end else begin
                check("idle_data", 32'(bus.out_data), 32'd0);
            end
        end
    end

    initial begin
        int rdy_pct;
        bus.en = 1'b0;  bus.foo = 1'b0;  bus.bar = 1'b0;
        bus.count_foo = 8'h00;  bus.count_bar = 8'h00;  bus.out_ready = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        started = 1'b1;

        // foo event at stamp 5 with count_foo=3, held then drained
        idle(5, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b1);

        // coincident foo and bar give one kind=11 record
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 8'd3, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);

        // ten events into a stalled FIFO, then drain
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'(i), 8'(100 + i), 1'b0);
        idle(1, 1'b0, 1'b0);
        idle(10, 1'b0, 1'b1);

        // full FIFO accepts an event when a pop happens on the same edge
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 8'(i), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 1'b1);
        idle(1, 1'b0, 1'b0);
        idle(10, 1'b0, 1'b1);

        // stamp wrap: events at enable cycles 255 and 256
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(255, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b1);
        idle(43, 1'b1, 1'b1);

        // reset mid-drain discards queued records
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'(20 + i), 8'(30 + i), 1'b0);
        idle(1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h88, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
        idle(3, 1'b1, 1'b1);

        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = 10 + 40 * int'($urandom_range(2));
            step($urandom_range(99) != 0,
                 $urandom_range(9) < 8,
                 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom),
                 int'($urandom_range(99)) < rdy_pct);
        end
        idle(20, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
